mpmc9_app_responder: RTL and testbench

// Synthesizable stand-in for the DDR3 MIG user (app_*) interface: the responder end of the command stream the

---
 rtl/mpmc9_app_responder_if.sv | 29 ++
 rtl/mpmc9_app_responder.sv | 176 +++++++++++++++++
 tb/tb_mpmc9_app_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc9_app_responder_if.sv
// MIG-style app_* user interface between the mpmc9 controller (master) and a
// memory responder (slave).
interface mpmc9_app_responder_if #(
  parameter int AWID = 29,
  parameter int DWID = 128
);
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [AWID-1:0]   app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DWID-1:0]   app_wdf_data;
  logic [DWID/8-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DWID-1:0]   app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mpmc9_app_responder.sv
// BRAM-backed stand-in for the DDR3 MIG user interface: in-order command queue,
// write-data FIFO, fixed-latency read pipe, emulated calibration and refresh stalls.
module mpmc9_app_responder #(
  parameter int AWID      = 29,
  parameter int DWID      = 128,
  parameter int MAW       = 10,
  parameter int RD_LAT    = 4,
  parameter int QDEPTH    = 4,
  parameter int CALIB_CYC = 16,
  parameter int REF_INT   = 64,
  parameter int REF_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_calib_complete,
  output logic                  err,
  mpmc9_app_responder_if.slave  app
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int QW     = $clog2(QDEPTH);
  localparam int CW     = $clog2(CALIB_CYC + 1);
  localparam int RIW    = (REF_INT > 1) ? $clog2(REF_INT) : 1;
  localparam int REF_LO = (REF_INT > REF_CYC) ? (REF_INT - REF_CYC) : 0;
  localparam int NB     = DWID / 8;

  logic [CW-1:0]   cal_cnt_r;
  logic            calib_r;
  logic [RIW-1:0]  ref_cnt_r;

  logic            cq_rd_r  [QDEPTH];
  logic [MAW-1:0]  cq_idx_r [QDEPTH];
  logic [QW-1:0]   cq_wp_r, cq_rp_r;
  logic [QW:0]     cq_cnt_r;

  logic [DWID-1:0] wd_dat_r [QDEPTH];
  logic [NB-1:0]   wd_msk_r [QDEPTH];
  logic [QW-1:0]   wd_wp_r, wd_rp_r;
  logic [QW:0]     wd_cnt_r;

  logic [DWID-1:0] mem_r [2**MAW];
  logic [DWID-1:0] rp_dat_r [RD_LAT];
  logic [RD_LAT-1:0] rp_vld_r;

  logic            calib_nxt_s;
  logic [RIW-1:0]  ref_cnt_nxt_s;
  logic            ref_nxt_s;
  logic            cmd_acc_s, cmd_ok_s, cq_push_s, wd_push_s;
  logic            head_rd_s;
  logic [MAW-1:0]  head_idx_s;
  logic            rd_pop_s, wr_pop_s, cq_pop_s;
  logic [QW:0]     cq_cnt_nxt_s, wd_cnt_nxt_s;
  logic            err_nxt_s;
  logic            addr_unused_s;

  assign init_calib_complete = calib_r;
  assign addr_unused_s       = ^app.app_addr[AWID-1:3+MAW];

  // Next-state of calibration/refresh timers, queue occupancy and error flag.
  always_comb begin
    calib_nxt_s   = calib_r | (cal_cnt_r == CW'(CALIB_CYC - 1));
    ref_cnt_nxt_s = {RIW{1'b0}};
    ref_nxt_s     = 1'b0;
    if (!calib_r) begin
      ref_cnt_nxt_s = {RIW{1'b0}};
    end else if (ref_cnt_r == RIW'(REF_INT - 1)) begin
      ref_cnt_nxt_s = {RIW{1'b0}};
    end else begin
      ref_cnt_nxt_s = ref_cnt_r + RIW'(1);
    end
    // Refresh occupies the last REF_CYC slots of each REF_INT period.
    if ((REF_INT != 0) && calib_r) begin
      ref_nxt_s = (ref_cnt_nxt_s >= RIW'(REF_LO));
    end else begin
      ref_nxt_s = 1'b0;
    end

    cmd_acc_s  = app.app_en & app.app_rdy;
    cmd_ok_s   = (app.app_cmd == CMD_WRITE) || (app.app_cmd == CMD_READ);
    cq_push_s  = cmd_acc_s & cmd_ok_s;
    wd_push_s  = app.app_wdf_wren & app.app_wdf_rdy;
    head_rd_s  = cq_rd_r[cq_rp_r];
    head_idx_s = cq_idx_r[cq_rp_r];
    rd_pop_s   = rst_n & (cq_cnt_r != (QW+1)'(0)) & head_rd_s;
    wr_pop_s   = rst_n & (cq_cnt_r != (QW+1)'(0)) & ~head_rd_s & (wd_cnt_r != (QW+1)'(0));
    cq_pop_s   = rd_pop_s | wr_pop_s;

    cq_cnt_nxt_s = cq_cnt_r + (QW+1)'(cq_push_s) - (QW+1)'(cq_pop_s);
    wd_cnt_nxt_s = wd_cnt_r + (QW+1)'(wd_push_s) - (QW+1)'(wr_pop_s);

    err_nxt_s = err
              | (cmd_acc_s & (~cmd_ok_s | (app.app_addr[2:0] != 3'b000)))
              | (wd_push_s & (app.app_wdf_end != app.app_wdf_wren));
  end

  // Control state, queue pointers, read-valid pipe and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_cnt_r             <= {CW{1'b0}};
      calib_r               <= 1'b0;
      ref_cnt_r             <= {RIW{1'b0}};
      cq_wp_r               <= {QW{1'b0}};
      cq_rp_r               <= {QW{1'b0}};
      cq_cnt_r              <= {(QW+1){1'b0}};
      wd_wp_r               <= {QW{1'b0}};
      wd_rp_r               <= {QW{1'b0}};
      wd_cnt_r              <= {(QW+1){1'b0}};
      rp_vld_r              <= {RD_LAT{1'b0}};
      app.app_rdy           <= 1'b0;
      app.app_wdf_rdy       <= 1'b0;
      app.app_rd_data       <= {DWID{1'b0}};
      app.app_rd_data_valid <= 1'b0;
      app.app_rd_data_end   <= 1'b0;
      err                   <= 1'b0;
    end else begin
      if (!calib_r) begin
        cal_cnt_r <= cal_cnt_r + CW'(1);
      end
      calib_r   <= calib_nxt_s;
      ref_cnt_r <= ref_cnt_nxt_s;

      if (cq_push_s) cq_wp_r <= cq_wp_r + QW'(1);
      if (cq_pop_s)  cq_rp_r <= cq_rp_r + QW'(1);
      if (wd_push_s) wd_wp_r <= wd_wp_r + QW'(1);
      if (wr_pop_s)  wd_rp_r <= wd_rp_r + QW'(1);
      cq_cnt_r <= cq_cnt_nxt_s;
      wd_cnt_r <= wd_cnt_nxt_s;

      // Ready looks at next occupancy, so a freed slot shows up one cycle later.
      app.app_rdy     <= calib_nxt_s & ~ref_nxt_s & (cq_cnt_nxt_s != (QW+1)'(QDEPTH));
      app.app_wdf_rdy <= calib_nxt_s & ~ref_nxt_s & (wd_cnt_nxt_s != (QW+1)'(QDEPTH));

      rp_vld_r[0] <= rd_pop_s;
      for (int k = 1; k < RD_LAT; k++) begin
        rp_vld_r[k] <= rp_vld_r[k-1];
      end
      app.app_rd_data_valid <= rp_vld_r[RD_LAT-1];
      app.app_rd_data_end   <= rp_vld_r[RD_LAT-1];
      if (rp_vld_r[RD_LAT-1]) begin
        app.app_rd_data <= rp_dat_r[RD_LAT-1];
      end
      err <= err_nxt_s;
    end
  end

  // Queue and write-data FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (cq_push_s) begin
      cq_rd_r[cq_wp_r]  <= (app.app_cmd == CMD_READ);
      cq_idx_r[cq_wp_r] <= app.app_addr[3 +: MAW];
    end
    if (wd_push_s) begin
      wd_dat_r[wd_wp_r] <= app.app_wdf_data;
      wd_msk_r[wd_wp_r] <= app.app_wdf_mask;
    end
  end

  // Memory array with byte-masked writes and the read data pipe (not reset).
  always_ff @(posedge clk) begin
    if (wr_pop_s) begin
      for (int b = 0; b < NB; b++) begin
        if (!wd_msk_r[wd_rp_r][b]) begin
          mem_r[head_idx_s][b*8 +: 8] <= wd_dat_r[wd_rp_r][b*8 +: 8];
        end
      end
    end
    if (rd_pop_s) begin
      rp_dat_r[0] <= mem_r[head_idx_s];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      rp_dat_r[k] <= rp_dat_r[k-1];
    end
  end

endmodule

// File: tb/tb_mpmc9_app_responder.sv
// Directed self-checking bench for mpmc9_app_responder: calibration, write/read,
// byte masks, queue backpressure, refresh stalls, protocol errors and reset flush.
module tb_mpmc9_app_responder;

  localparam int AWID = 29, DWID = 128, MAW = 10, RD_LAT = 4, QDEPTH = 4;
  localparam int CALIB_CYC = 16, REF_INT = 64, REF_CYC = 4;
  localparam logic [2:0] WR = 3'b000, RD = 3'b001;
  localparam logic [DWID-1:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AA55;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib, err;
  int   n_pass = 0, n_chk = 0;
  int   cyc = 0;
  logic [DWID-1:0] rd_q[$];
  int              rd_t[$];

  mpmc9_app_responder_if #(.AWID(AWID), .DWID(DWID)) app_if();

  mpmc9_app_responder #(
    .AWID(AWID), .DWID(DWID), .MAW(MAW), .RD_LAT(RD_LAT), .QDEPTH(QDEPTH),
    .CALIB_CYC(CALIB_CYC), .REF_INT(REF_INT), .REF_CYC(REF_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .err(err), .app(app_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-return monitor: records data and the edge count it appeared after.
  always @(negedge clk) begin
    if (app_if.app_rd_data_valid === 1'b1) begin
      rd_q.push_back(app_if.app_rd_data);
      rd_t.push_back(cyc);
    end
  end

  task automatic idle_inputs();
    app_if.app_en = 1'b0; app_if.app_cmd = 3'b000; app_if.app_addr = '0;
    app_if.app_wdf_wren = 1'b0; app_if.app_wdf_end = 1'b0;
    app_if.app_wdf_data = '0; app_if.app_wdf_mask = '0;
  endtask

  task automatic reset_dut();
    int n = 0;
    @(negedge clk); rst_n = 1'b0; idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (calib !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_chk++;
    if (calib !== 1'b1) $display("FAIL calib_wait: got %b want 1", calib); else n_pass++;
    @(posedge clk); #1; rd_q.delete(); rd_t.delete();
  endtask

  task automatic put_cmd(input logic [2:0] c, input logic [AWID-1:0] a, output int acc);
    int n = 0;
    @(negedge clk); app_if.app_en = 1'b1; app_if.app_cmd = c; app_if.app_addr = a;
    while (app_if.app_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_chk++;
    if (app_if.app_rdy !== 1'b1) $display("FAIL cmd_accept: app_rdy %b want 1", app_if.app_rdy); else n_pass++;
    @(posedge clk); #1; acc = cyc; app_if.app_en = 1'b0;
  endtask

  task automatic put_wd(input logic [DWID-1:0] d, input logic [DWID/8-1:0] m);
    int n = 0;
    @(negedge clk); app_if.app_wdf_wren = 1'b1; app_if.app_wdf_end = 1'b1;
    app_if.app_wdf_data = d; app_if.app_wdf_mask = m;
    while (app_if.app_wdf_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_chk++;
    if (app_if.app_wdf_rdy !== 1'b1) $display("FAIL wd_accept: app_wdf_rdy %b want 1", app_if.app_wdf_rdy); else n_pass++;
    @(posedge clk); #1; app_if.app_wdf_wren = 1'b0; app_if.app_wdf_end = 1'b0;
  endtask

  // Command and its data presented in the same cycle.
  task automatic wr_both(input logic [AWID-1:0] a, input logic [DWID-1:0] d, input logic [DWID/8-1:0] m);
    int n = 0;
    @(negedge clk);
    app_if.app_en = 1'b1; app_if.app_cmd = WR; app_if.app_addr = a;
    app_if.app_wdf_wren = 1'b1; app_if.app_wdf_end = 1'b1; app_if.app_wdf_data = d; app_if.app_wdf_mask = m;
    while (!(app_if.app_rdy === 1'b1 && app_if.app_wdf_rdy === 1'b1) && n < 100) begin @(negedge clk); n++; end
    n_chk++;
    if (!(app_if.app_rdy === 1'b1 && app_if.app_wdf_rdy === 1'b1))
      $display("FAIL wr_both_accept: rdy %b wdf_rdy %b want 1 1", app_if.app_rdy, app_if.app_wdf_rdy);
    else n_pass++;
    @(posedge clk); #1;
    app_if.app_en = 1'b0; app_if.app_wdf_wren = 1'b0; app_if.app_wdf_end = 1'b0;
  endtask

  task automatic get_rd(output logic [DWID-1:0] d, output int t);
    int n = 0;
    while (rd_q.size() == 0 && n < 30) begin @(posedge clk); n++; end
    n_chk++;
    if (rd_q.size() == 0) begin
      $display("FAIL rd_timeout: no app_rd_data_valid within 30 cycles");
      d = '0; t = -1;
    end else begin
      n_pass++;
      d = rd_q.pop_front(); t = rd_t.pop_front();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (3) @(negedge clk);
    n_chk++; if (calib !== 1'b0) $display("FAIL rst_calib: got %b want 0", calib); else n_pass++;
    n_chk++; if (app_if.app_rdy !== 1'b0) $display("FAIL rst_rdy: got %b want 0", app_if.app_rdy); else n_pass++;
    n_chk++; if (app_if.app_wdf_rdy !== 1'b0) $display("FAIL rst_wdf_rdy: got %b want 0", app_if.app_wdf_rdy); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_chk++; if (app_if.app_rd_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", app_if.app_rd_data_valid); else n_pass++;
    n_chk++; if (app_if.app_rd_data !== '0) $display("FAIL rst_rd_data: got %h want 0", app_if.app_rd_data); else n_pass++;
    rst_n = 1'b1;
    // Calibration completes on the 16th edge after release.
    for (int i = 1; i <= 18; i++) begin
      logic ex;
      @(negedge clk);
      ex = (i >= CALIB_CYC);
      n_chk++; if (calib !== ex) $display("FAIL calib_edge%0d: got %b want %b", i, calib, ex); else n_pass++;
      n_chk++; if (app_if.app_rdy !== ex) $display("FAIL rdy_edge%0d: got %b want %b", i, app_if.app_rdy, ex); else n_pass++;
      n_chk++; if (app_if.app_wdf_rdy !== ex) $display("FAIL wdf_rdy_edge%0d: got %b want %b", i, app_if.app_wdf_rdy, ex); else n_pass++;
    end
    n_chk++; if (err !== 1'b0) $display("FAIL calib_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [DWID-1:0] d; int t, acc;
    reset_dut();
    wr_both(29'h40, D2, '0);
    put_cmd(RD, 29'h40, acc);
    get_rd(d, t);
    n_chk++; if (d !== D2) $display("FAIL wr_rd_data: got %h want %h", d, D2); else n_pass++;
    // Executes one edge after acceptance, then RD_LAT more edges.
    n_chk++; if (t - acc !== RD_LAT + 1) $display("FAIL wr_rd_latency: got %0d want %0d", t - acc, RD_LAT + 1); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (app_if.app_rd_data !== D2) $display("FAIL rd_data_hold: got %h want %h", app_if.app_rd_data, D2); else n_pass++;
    n_chk++; if (app_if.app_rd_data_valid !== 1'b0) $display("FAIL rd_valid_drop: got %b want 0", app_if.app_rd_data_valid); else n_pass++;
    // Bit 13 lies above the beat index and must alias onto 0x40.
    put_cmd(RD, 29'h2040, acc);
    get_rd(d, t);
    n_chk++; if (d !== D2) $display("FAIL alias_rd: got %h want %h", d, D2); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL wr_rd_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_masked_write();
    logic [DWID-1:0] d, ex; int t, acc;
    reset_dut();
    wr_both(29'h80, {DWID{1'b1}}, '0);
    wr_both(29'h80, '0, 16'h00FF);
    put_cmd(RD, 29'h80, acc);
    get_rd(d, t);
    ex = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    n_chk++; if (d !== ex) $display("FAIL masked_data: got %h want %h", d, ex); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] rdy_seen;
    logic [DWID-1:0] d;
    int t, acc, sent_d, n;
    logic c5_done, a_c, a_d;
    reset_dut();
    rdy_seen = 5'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      app_if.app_en = 1'b1; app_if.app_cmd = WR; app_if.app_addr = 29'h100 + 29'(i * 8);
      rdy_seen[i] = app_if.app_rdy;
      @(posedge clk);
    end
    n_chk++; if (rdy_seen !== 5'b01111) $display("FAIL b2b_rdy_pattern: got %b want 01111", rdy_seen); else n_pass++;
    sent_d = 0; c5_done = 1'b0; n = 0;
    while ((sent_d < 5 || !c5_done) && n < 50) begin
      @(negedge clk);
      app_if.app_en = !c5_done;
      app_if.app_wdf_wren = (sent_d < 5); app_if.app_wdf_end = (sent_d < 5);
      app_if.app_wdf_data = {4{32'hC0DE_0000 + 32'(sent_d)}}; app_if.app_wdf_mask = '0;
      a_c = app_if.app_en & app_if.app_rdy;
      a_d = app_if.app_wdf_wren & app_if.app_wdf_rdy;
      @(posedge clk);
      if (a_c) c5_done = 1'b1;
      if (a_d) sent_d++;
      n++;
    end
    @(negedge clk); idle_inputs();
    n_chk++; if (c5_done !== 1'b1) $display("FAIL b2b_cmd5_accept: got %b want 1", c5_done); else n_pass++;
    for (int i = 0; i < 5; i++) put_cmd(RD, 29'h100 + 29'(i * 8), acc);
    for (int i = 0; i < 5; i++) begin
      get_rd(d, t);
      n_chk++;
      if (d !== {4{32'hC0DE_0000 + 32'(i)}}) $display("FAIL b2b_rd%0d: got %h want %h", i, d, {4{32'hC0DE_0000 + 32'(i)}});
      else n_pass++;
    end
  endtask

  task automatic test_refresh();
    logic [DWID-1:0] exp_q[$];
    int starts[$], lens[$];
    int low_len, k, acc, t, n;
    logic r, prev;
    logic [DWID-1:0] d;
    reset_dut();
    // Data ahead of its command.
    for (int i = 0; i < 8; i++) begin
      put_wd({4{32'h5EED_0000 + 32'(i)}}, '0);
      put_cmd(WR, 29'h200 + 29'(i * 8), acc);
    end
    low_len = 0; k = 0; prev = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      app_if.app_en = 1'b1; app_if.app_cmd = RD; app_if.app_addr = 29'h200 + 29'((k % 8) * 8);
      r = app_if.app_rdy;
      if (r) exp_q.push_back({4{32'h5EED_0000 + 32'(k % 8)}});
      if (!r) low_len++;
      if (!r && prev) starts.push_back(c);
      if (r && !prev) begin lens.push_back(low_len); low_len = 0; end
      prev = r;
      @(posedge clk);
      if (r) k++;
    end
    @(negedge clk); idle_inputs();
    n_chk++; if (starts.size() < 3) $display("FAIL ref_runs: got %0d want >=3", starts.size()); else n_pass++;
    for (int i = 0; i < lens.size(); i++) begin
      n_chk++; if (lens[i] !== REF_CYC) $display("FAIL ref_len%0d: got %0d want %0d", i, lens[i], REF_CYC); else n_pass++;
    end
    for (int i = 1; i < starts.size(); i++) begin
      n_chk++;
      if (starts[i] - starts[i-1] !== REF_INT) $display("FAIL ref_gap%0d: got %0d want %0d", i, starts[i] - starts[i-1], REF_INT);
      else n_pass++;
    end
    n = 0;
    while (rd_q.size() < exp_q.size() && n < 30) begin @(posedge clk); n++; end
    n_chk++; if (rd_q.size() !== exp_q.size()) $display("FAIL ref_rd_count: got %0d want %0d", rd_q.size(), exp_q.size()); else n_pass++;
    while (rd_q.size() > 0 && exp_q.size() > 0) begin
      get_rd(d, t);
      n_chk++;
      if (d !== exp_q[0]) $display("FAIL ref_rd_order: got %h want %h", d, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_err_reset();
    logic [DWID-1:0] d; int t, acc;
    reset_dut();
    put_cmd(3'b010, 29'h0, acc);
    @(negedge clk);
    n_chk++; if (err !== 1'b1) $display("FAIL err_badcmd: got %b want 1", err); else n_pass++;
    // Misaligned address still executes with the low bits ignored.
    put_cmd(RD, 29'h41, acc);
    get_rd(d, t);
    n_chk++; if (d !== D2) $display("FAIL misaligned_rd: got %h want %h", d, D2); else n_pass++;
    put_cmd(RD, 29'h41, acc);
    put_cmd(RD, 29'h80, acc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else n_pass++;
    n_chk++; if (calib !== 1'b0) $display("FAIL calib_cleared: got %b want 0", calib); else n_pass++;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_chk++; if (rd_q.size() !== 0) $display("FAIL flushed_reads: got %0d valid beats want 0", rd_q.size()); else n_pass++;
    reset_dut();
    @(negedge clk);
    app_if.app_wdf_wren = 1'b1; app_if.app_wdf_end = 1'b0; app_if.app_wdf_data = '0;
    @(posedge clk); #1; app_if.app_wdf_wren = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (err !== 1'b1) $display("FAIL err_wdf_end: got %b want 1", err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_refresh();
    test_err_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
